// File: rtl/seq_pkg.sv
// Shared types and default widths for the bit-serial detector sequencer.
`timescale 1ns/1ps
package seq_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } seq_state_t;

    localparam int WORD_W_DEF = 8;
    localparam int CNT_W_DEF  = 8;
endpackage

// File: rtl/seq_piso.sv
// Parallel-in serial-out word register with a bit index and last-bit flag.
`timescale 1ns/1ps
module seq_piso #(
    parameter int WORD_W    = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clr,
    input  logic              load,
    input  logic              shift,
    input  logic [WORD_W-1:0] data,
    output logic              bit_out,
    output logic              last
);
    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

    logic [WORD_W-1:0] sreg;
    logic [IDX_W-1:0]  bit_idx;

    // clr drops a partial word; load wins over shift so a back-to-back word lands on the last bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sreg    <= '0;
            bit_idx <= '0;
        end else if (clr) begin
            sreg    <= '0;
            bit_idx <= '0;
        end else if (load) begin
            sreg    <= data;
            bit_idx <= '0;
        end else if (shift) begin
            sreg    <= MSB_FIRST ? {sreg[WORD_W-2:0], 1'b0} : {1'b0, sreg[WORD_W-1:1]};
            bit_idx <= last ? '0 : bit_idx + 1'b1;
        end
    end

    assign bit_out = MSB_FIRST ? sreg[WORD_W-1] : sreg[0];
    assign last    = (bit_idx == LAST_IDX);
endmodule

// File: rtl/seq_stream_ctrl.sv
// Feeds handshaked words bit-serially into a "0110" Mealy detector, owns its reset,
// and counts matches with a saturating counter and sticky threshold flag.
`timescale 1ns/1ps
module seq_stream_ctrl
    import seq_pkg::*;
#(
    parameter int WORD_W    = WORD_W_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              stop,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    output logic              det_x,
    output logic              det_rst,
    input  logic              det_z,
    input  logic [CNT_W-1:0]  thresh,
    output logic              match_pulse,
    output logic [CNT_W-1:0]  match_cnt,
    output logic              thresh_hit,
    output logic              busy
);
    seq_state_t       state, state_nxt;
    logic             hs;
    logic             last_bit;
    logic             piso_bit;
    logic             shift_hit;
    logic             stats_clr;
    logic [CNT_W-1:0] cnt_upd;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nxt = LOAD;
                LOAD:    if (hs) state_nxt = SHIFT;
                         else if (stop) state_nxt = IDLE;
                SHIFT:   if (last_bit && !hs) state_nxt = stop ? IDLE : LOAD;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Ready on the last bit lets the next word follow with no bubble, keeping the detector live
    always_comb begin
        in_ready = 1'b0;
        if (!flush) begin
            if (state == LOAD)       in_ready = 1'b1;
            else if (state == SHIFT) in_ready = last_bit && !stop;
        end
        det_rst = (state != SHIFT);
        busy    = (state != IDLE);
        det_x   = (state == SHIFT) ? piso_bit : 1'b0;
    end

    assign hs = in_valid && in_ready;

    seq_piso #(
        .WORD_W    (WORD_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_piso (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (flush),
        .load    (hs),
        .shift   (state == SHIFT),
        .data    (in_data),
        .bit_out (piso_bit),
        .last    (last_bit)
    );

    assign shift_hit = (state == SHIFT) && det_z;
    assign stats_clr = (state == IDLE) && start && !flush;
    assign cnt_upd   = sat_inc(match_cnt);

    // thresh_hit is sticky: only start or reset clears it, never a thresh change
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            match_pulse <= 1'b0;
            match_cnt   <= '0;
            thresh_hit  <= 1'b0;
        end else begin
            match_pulse <= shift_hit;
            if (stats_clr) begin
                match_cnt  <= '0;
                thresh_hit <= 1'b0;
            end else if (shift_hit) begin
                match_cnt <= cnt_upd;
                if ((thresh != '0) && (cnt_upd >= thresh)) thresh_hit <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_seq_stream_ctrl.sv
// Directed bench for seq_stream_ctrl driving a behavioural "0110" Mealy detector.
`timescale 1ns/1ps
module tb_seq_stream_ctrl;
    logic       clk = 1'b0;
    logic       reset_n, start, stop, flush, in_valid;
    logic [7:0] in_data;
    logic [7:0] thresh;
    logic [1:0] thresh2;

    logic       in_ready, det_x, det_rst, det_z, match_pulse, thresh_hit, busy;
    logic [7:0] match_cnt;
    logic       in_ready2, det_x2, det_rst2, det_z2, match_pulse2, thresh_hit2, busy2;
    logic [1:0] match_cnt2;
    logic [1:0] ds, ds2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_stream_ctrl #(.WORD_W(8), .CNT_W(8), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .det_x(det_x),
        .det_rst(det_rst), .det_z(det_z), .thresh(thresh), .match_pulse(match_pulse),
        .match_cnt(match_cnt), .thresh_hit(thresh_hit), .busy(busy)
    );

    seq_stream_ctrl #(.WORD_W(8), .CNT_W(2), .MSB_FIRST(1'b1)) dut2 (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready2), .det_x(det_x2),
        .det_rst(det_rst2), .det_z(det_z2), .thresh(thresh2), .match_pulse(match_pulse2),
        .match_cnt(match_cnt2), .thresh_hit(thresh_hit2), .busy(busy2)
    );

    // 0110 Mealy detector: states count the matched prefix length
    function automatic logic [1:0] det_next(input logic [1:0] s, input logic x);
        case (s)
            2'd0:    return x ? 2'd0 : 2'd1;
            2'd1:    return x ? 2'd2 : 2'd1;
            2'd2:    return x ? 2'd3 : 2'd1;
            default: return x ? 2'd0 : 2'd1;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        ds  <= det_rst  ? 2'd0 : det_next(ds, det_x);
        ds2 <= det_rst2 ? 2'd0 : det_next(ds2, det_x2);
    end
    assign det_z  = (ds == 2'd3) && !det_x;
    assign det_z2 = (ds2 == 2'd3) && !det_x2;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; stop = 1'b0; flush = 1'b0;
        in_valid = 1'b0; in_data = 8'h00; thresh = 8'd0; thresh2 = 2'd0;
        tick(); tick();
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
        checks++; if (det_x !== 1'b0) begin failures++; $display("FAIL reset_det_x got=%0b exp=0", det_x); end
        checks++; if (det_rst !== 1'b1) begin failures++; $display("FAIL reset_det_rst got=%0b exp=1", det_rst); end
        checks++; if (match_pulse !== 1'b0) begin failures++; $display("FAIL reset_match_pulse got=%0b exp=0", match_pulse); end
        checks++; if (match_cnt !== 8'd0) begin failures++; $display("FAIL reset_match_cnt got=%0d exp=0", match_cnt); end
        checks++; if (thresh_hit !== 1'b0) begin failures++; $display("FAIL reset_thresh_hit got=%0b exp=0", thresh_hit); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        reset_n = 1'b1;
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_release_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_single_word();
        logic [9:0] pulses;
        logic [7:0] xs;
        logic       rst_low;
        do_start();
        in_valid = 1'b1; in_data = 8'h36; stop = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL single_load_ready got=%0b exp=1", in_ready); end
        tick();
        in_valid = 1'b0; stop = 1'b1;
        pulses = '0; xs = '0; rst_low = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            pulses[c] = match_pulse;
            if (c < 8) begin
                xs[7-c] = det_x;
                if (det_rst !== 1'b0) rst_low = 1'b0;
            end
            if (c == 5) begin
                checks++; if (match_cnt !== 8'd1) begin failures++; $display("FAIL single_cnt_mid got=%0d exp=1", match_cnt); end
            end
            if (c == 7) begin
                checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL single_last_ready_stop got=%0b exp=0", in_ready); end
            end
            if (c == 8) begin
                checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_end got=%0b exp=0", busy); end
                checks++; if (det_rst !== 1'b1) begin failures++; $display("FAIL single_det_rst_end got=%0b exp=1", det_rst); end
            end
            tick();
        end
        checks++; if (xs !== 8'h36) begin failures++; $display("FAIL single_det_x_stream got=%h exp=36", xs); end
        checks++; if (rst_low !== 1'b1) begin failures++; $display("FAIL single_det_rst_shift got=%0b exp=1", rst_low); end
        checks++; if (pulses !== 10'h120) begin failures++; $display("FAIL single_pulses got=%h exp=120", pulses); end
        checks++; if (match_cnt !== 8'd2) begin failures++; $display("FAIL single_cnt got=%0d exp=2", match_cnt); end
        stop = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [17:0] pulses;
        logic [15:0] xs;
        do_start();
        in_valid = 1'b1; in_data = 8'h01; stop = 1'b0;
        tick();
        in_data = 8'h80;
        pulses = '0; xs = '0;
        for (int c = 0; c < 18; c++) begin
            if (c == 8) begin in_valid = 1'b0; stop = 1'b1; end
            #1;
            pulses[c] = match_pulse;
            if (c < 16) xs[15-c] = det_x;
            if (c == 7) begin
                checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_last_ready got=%0b exp=1", in_ready); end
            end
            if (c == 8) begin
                checks++; if (det_rst !== 1'b0) begin failures++; $display("FAIL b2b_no_bubble got=%0b exp=0", det_rst); end
            end
            if (c == 16) begin
                checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_busy_end got=%0b exp=0", busy); end
            end
            tick();
        end
        checks++; if (xs !== 16'h0180) begin failures++; $display("FAIL b2b_det_x_stream got=%h exp=0180", xs); end
        checks++; if (pulses !== 18'h00400) begin failures++; $display("FAIL b2b_pulses got=%h exp=00400", pulses); end
        checks++; if (match_cnt !== 8'd1) begin failures++; $display("FAIL b2b_cnt got=%0d exp=1", match_cnt); end
        stop = 1'b0;
    endtask

    task automatic test_bubble();
        logic [18:0] pulses;
        do_start();
        in_valid = 1'b1; in_data = 8'h01; stop = 1'b0;
        tick();
        in_valid = 1'b0;
        pulses = '0;
        for (int c = 0; c < 19; c++) begin
            if (c == 8) begin in_valid = 1'b1; in_data = 8'h80; end
            if (c == 9) begin in_valid = 1'b0; stop = 1'b1; end
            #1;
            pulses[c] = match_pulse;
            if (c == 8) begin
                checks++; if (det_rst !== 1'b1) begin failures++; $display("FAIL bubble_det_rst got=%0b exp=1", det_rst); end
                checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bubble_load_ready got=%0b exp=1", in_ready); end
            end
            if (c == 17) begin
                checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bubble_busy_end got=%0b exp=0", busy); end
            end
            tick();
        end
        checks++; if (pulses !== 19'h0) begin failures++; $display("FAIL bubble_pulses got=%h exp=0", pulses); end
        checks++; if (match_cnt !== 8'd0) begin failures++; $display("FAIL bubble_cnt got=%0d exp=0", match_cnt); end
        stop = 1'b0;
    endtask

    task automatic test_saturate();
        logic [17:0] pulses;
        thresh = 8'd0; thresh2 = 2'd2;
        do_start();
        in_valid = 1'b1; in_data = 8'h66; stop = 1'b0;
        tick();
        pulses = '0;
        for (int c = 0; c < 18; c++) begin
            if (c == 8) begin in_valid = 1'b0; stop = 1'b1; end
            #1;
            pulses[c] = match_pulse2;
            if (c == 7) begin
                checks++; if (match_cnt2 !== 2'd1) begin failures++; $display("FAIL sat_cnt_c7 got=%0d exp=1", match_cnt2); end
                checks++; if (thresh_hit2 !== 1'b0) begin failures++; $display("FAIL sat_hit_early got=%0b exp=0", thresh_hit2); end
                checks++; if (in_ready2 !== 1'b1) begin failures++; $display("FAIL sat_last_ready got=%0b exp=1", in_ready2); end
            end
            if (c == 8) begin
                checks++; if (match_cnt2 !== 2'd2) begin failures++; $display("FAIL sat_cnt_c8 got=%0d exp=2", match_cnt2); end
                checks++; if (thresh_hit2 !== 1'b1) begin failures++; $display("FAIL sat_hit_rise got=%0b exp=1", thresh_hit2); end
                checks++; if (det_rst2 !== 1'b0) begin failures++; $display("FAIL sat_no_bubble got=%0b exp=0", det_rst2); end
                checks++; if (det_x2 !== 1'b0) begin failures++; $display("FAIL sat_word2_bit0 got=%0b exp=0", det_x2); end
            end
            if (c == 12) begin
                checks++; if (match_cnt2 !== 2'd3) begin failures++; $display("FAIL sat_cnt_c12 got=%0d exp=3", match_cnt2); end
            end
            if (c == 16) begin
                checks++; if (match_cnt2 !== 2'd3) begin failures++; $display("FAIL sat_cnt_hold got=%0d exp=3", match_cnt2); end
                checks++; if (thresh_hit2 !== 1'b1) begin failures++; $display("FAIL sat_hit_sticky got=%0b exp=1", thresh_hit2); end
                checks++; if (match_cnt !== 8'd4) begin failures++; $display("FAIL sat_wide_cnt got=%0d exp=4", match_cnt); end
                checks++; if (thresh_hit !== 1'b0) begin failures++; $display("FAIL sat_thresh0_disabled got=%0b exp=0", thresh_hit); end
                checks++; if (busy2 !== 1'b0) begin failures++; $display("FAIL sat_busy_end got=%0b exp=0", busy2); end
            end
            tick();
        end
        checks++; if (pulses !== 18'h11110) begin failures++; $display("FAIL sat_pulses got=%h exp=11110", pulses); end
        thresh2 = 2'd3;
        tick();
        checks++; if (thresh_hit2 !== 1'b1) begin failures++; $display("FAIL sat_thresh_raise got=%0b exp=1", thresh_hit2); end
        thresh2 = 2'd0;
        tick();
        checks++; if (thresh_hit2 !== 1'b1) begin failures++; $display("FAIL sat_thresh_zero got=%0b exp=1", thresh_hit2); end
        do_start();
        checks++; if (thresh_hit2 !== 1'b0) begin failures++; $display("FAIL sat_start_clr_hit got=%0b exp=0", thresh_hit2); end
        checks++; if (match_cnt2 !== 2'd0) begin failures++; $display("FAIL sat_start_clr_cnt got=%0d exp=0", match_cnt2); end
        tick();
        stop = 1'b0;
    endtask

    task automatic test_flush();
        logic [12:0] pulses;
        do_start();
        in_valid = 1'b1; in_data = 8'h36; stop = 1'b0;
        tick();
        pulses = '0;
        for (int c = 0; c < 13; c++) begin
            if (c == 8)  in_valid = 1'b0;
            if (c == 11) flush = 1'b1;
            if (c == 12) flush = 1'b0;
            #1;
            pulses[c] = match_pulse;
            if (c == 11) begin
                checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_ready got=%0b exp=0", in_ready); end
            end
            if (c == 12) begin
                checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_busy got=%0b exp=0", busy); end
                checks++; if (det_rst !== 1'b1) begin failures++; $display("FAIL flush_det_rst got=%0b exp=1", det_rst); end
                checks++; if (det_x !== 1'b0) begin failures++; $display("FAIL flush_det_x got=%0b exp=0", det_x); end
                checks++; if (match_cnt !== 8'd2) begin failures++; $display("FAIL flush_cnt_kept got=%0d exp=2", match_cnt); end
            end
            tick();
        end
        checks++; if (pulses !== 13'h0120) begin failures++; $display("FAIL flush_pulses got=%h exp=0120", pulses); end
        start = 1'b1; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_start_busy got=%0b exp=0", busy); end
        checks++; if (match_cnt !== 8'd2) begin failures++; $display("FAIL flush_start_cnt got=%0d exp=2", match_cnt); end
        do_start();
        checks++; if (match_cnt !== 8'd0) begin failures++; $display("FAIL flush_restart_cnt got=%0d exp=0", match_cnt); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL flush_restart_busy got=%0b exp=1", busy); end
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic test_async_reset();
        do_start();
        in_valid = 1'b1; in_data = 8'h36; stop = 1'b0;
        tick();
        in_valid = 1'b0; stop = 1'b1;
        for (int c = 0; c < 5; c++) tick();
        checks++; if (match_cnt !== 8'd1) begin failures++; $display("FAIL arst_pre_cnt got=%0d exp=1", match_cnt); end
        #1 reset_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL arst_busy got=%0b exp=0", busy); end
        checks++; if (det_rst !== 1'b1) begin failures++; $display("FAIL arst_det_rst got=%0b exp=1", det_rst); end
        checks++; if (det_x !== 1'b0) begin failures++; $display("FAIL arst_det_x got=%0b exp=0", det_x); end
        checks++; if (match_pulse !== 1'b0) begin failures++; $display("FAIL arst_pulse got=%0b exp=0", match_pulse); end
        checks++; if (match_cnt !== 8'd0) begin failures++; $display("FAIL arst_cnt got=%0d exp=0", match_cnt); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL arst_ready got=%0b exp=0", in_ready); end
        tick();
        reset_n = 1'b1; stop = 1'b0;
        tick();
        do_start();
        in_valid = 1'b1; in_data = 8'h36;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL arst_load_ready got=%0b exp=1", in_ready); end
        tick();
        in_valid = 1'b0; stop = 1'b1;
        for (int c = 0; c < 9; c++) tick();
        checks++; if (match_cnt !== 8'd2) begin failures++; $display("FAIL arst_after_cnt got=%0d exp=2", match_cnt); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL arst_after_busy got=%0b exp=0", busy); end
        stop = 1'b0;
    endtask

    task automatic test_start_while_busy();
        do_start();
        in_valid = 1'b1; in_data = 8'h36; stop = 1'b0;
        tick();
        in_valid = 1'b0; stop = 1'b1;
        for (int c = 0; c < 5; c++) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (match_cnt !== 8'd1) begin failures++; $display("FAIL busy_start_cnt got=%0d exp=1", match_cnt); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL busy_start_state got=%0b exp=1", busy); end
        tick(); tick();
        checks++; if (match_cnt !== 8'd2) begin failures++; $display("FAIL busy_start_end_cnt got=%0d exp=2", match_cnt); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_start_end_busy got=%0b exp=0", busy); end
        stop = 1'b0;
    endtask

    task automatic test_stop_in_load();
        logic [7:0] xs;
        do_start();
        stop = 1'b1; in_valid = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stopload_busy got=%0b exp=0", busy); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stopload_ready got=%0b exp=0", in_ready); end
        stop = 1'b0;
        do_start();
        in_valid = 1'b1; in_data = 8'h36;
        tick();
        in_valid = 1'b0; stop = 1'b1;
        xs = '0;
        for (int c = 0; c < 8; c++) begin
            #1;
            xs[7-c] = det_x;
            tick();
        end
        checks++; if (xs !== 8'h36) begin failures++; $display("FAIL stopload_word got=%h exp=36", xs); end
        checks++; if (match_cnt !== 8'd2) begin failures++; $display("FAIL stopload_cnt got=%0d exp=2", match_cnt); end
        stop = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_bubble();
        test_saturate();
        test_flush();
        test_async_reset();
        test_start_while_busy();
        test_stop_in_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
